// File: rtl/fault_scan_ctrl.sv
// Scans the fault memory word by word and builds per-word flip/patch maps plus fault counters.
// Start to done takes N_WORDS+2 cycles (one read per cycle, then a one-cycle drain for the last return).
module fault_scan_ctrl #(
    parameter int N_WORDS = 64,
    parameter int ADDR_W  = $clog2(N_WORDS),
    parameter int CNT_W   = ADDR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic [1:0]         mem_rd_data,
    output logic               busy,
    output logic               done,
    output logic [N_WORDS-1:0] flip_map,
    output logic [N_WORDS-1:0] patch_map,
    output logic [CNT_W-1:0]   count_f,
    output logic [CNT_W-1:0]   count_p,
    output logic [CNT_W-1:0]   count_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [ADDR_W-1:0]   cap_addr;
    logic                cap_vld;
    logic                scan_go;
    logic                last_addr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A start is only honoured when no scan is running
    assign scan_go   = start && ((state == IDLE) || (state == DONE));
    assign last_addr = (addr_cnt == ADDR_W'(N_WORDS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state)
            IDLE: begin
                if (scan_go) state_nxt = SCAN;
            end
            SCAN: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = addr_cnt;
                busy        = 1'b1;
                if (last_addr) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (scan_go) state_nxt = SCAN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_cnt <= '0;
        end else if (scan_go) begin
            addr_cnt <= '0;
        end else if (state == SCAN) begin
            addr_cnt <= addr_cnt + 1'b1;
        end
    end

    // Read data returns one cycle after the strobe, so the address travels with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_vld  <= 1'b0;
            cap_addr <= '0;
        end else begin
            cap_vld  <= mem_rd_en;
            cap_addr <= mem_rd_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flip_map  <= '0;
            patch_map <= '0;
            count_f   <= '0;
            count_p   <= '0;
            count_err <= '0;
        end else if (scan_go) begin
            flip_map  <= '0;
            patch_map <= '0;
            count_f   <= '0;
            count_p   <= '0;
            count_err <= '0;
        end else if (cap_vld) begin
            unique case (mem_rd_data)
                2'b01: begin
                    flip_map[cap_addr] <= 1'b1;
                    count_f            <= sat_inc(count_f);
                end
                2'b10: begin
                    patch_map[cap_addr] <= 1'b1;
                    count_p             <= sat_inc(count_p);
                end
                2'b11: begin
                    count_err <= sat_inc(count_err);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
